// File: rtl/lane_serializer.sv
// lane_serializer: snapshots the lane array outputs into a small circular
// buffer and drains each snapshot as a serial frame (lane 0 first) over a
// valid/ready stream with start/end-of-frame markers.
//
// state  | meaning
// IDLE   | no frame in flight; pops the head snapshot as soon as one exists
// SHIFT  | presenting beats of the current frame; reloads back-to-back
module lane_serializer #(
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] lane_y,
  input  logic                 cap,
  output logic                 cap_ready,
  output logic                 ser_data,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_sof,
  output logic                 ser_eof,
  output logic                 ovf,
  input  logic                 clr_ovf,
  output logic [15:0]          frame_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(NUM_LANES);
  localparam int CW = PW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LANES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  logic [NUM_LANES-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  state_t               state;
  logic [NUM_LANES-1:0] shreg;
  logic [IW-1:0]        idx;

  logic                 push;
  logic                 drop;
  logic                 pop;
  logic                 last_acc;
  logic [NUM_LANES-1:0] head;

  // Space is judged on the registered count only; a pop this cycle does not
  // free a slot for a capture in the same cycle.
  assign cap_ready = (count < DEPTH_C);

  // Capture/pop qualification and the buffer head.
  always_comb begin
    push     = cap && cap_ready;
    drop     = cap && !cap_ready;
    head     = mem[rd_ptr];
    last_acc = (state == S_SHIFT) && ser_ready && (idx == LAST_IDX);
    pop      = (count != '0) && ((state == S_IDLE) || last_acc);
  end

  // Snapshot storage; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lane_y;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame FSM with registered stream outputs; outputs only move on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      idx       <= '0;
      ser_valid <= 1'b0;
      ser_data  <= 1'b0;
      ser_sof   <= 1'b0;
      ser_eof   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state     <= S_SHIFT;
            shreg     <= head;
            idx       <= '0;
            ser_valid <= 1'b1;
            ser_data  <= head[0];
            ser_sof   <= 1'b1;
            ser_eof   <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (ser_ready) begin
            if (idx == LAST_IDX) begin
              frame_cnt <= frame_cnt + 16'd1;
              if (pop) begin
                shreg    <= head;
                idx      <= '0;
                ser_data <= head[0];
                ser_sof  <= 1'b1;
                ser_eof  <= 1'b0;
              end else begin
                state     <= S_IDLE;
                ser_valid <= 1'b0;
                ser_data  <= 1'b0;
                ser_sof   <= 1'b0;
                ser_eof   <= 1'b0;
              end
            end else begin
              shreg    <= shreg >> 1;
              idx      <= idx + IW'(1);
              ser_data <= shreg[1];
              ser_sof  <= 1'b0;
              ser_eof  <= ((idx + IW'(1)) == LAST_IDX);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer (NUM_LANES=4, DEPTH=2). Cycle k is the
// interval after the k-th rising edge of the test; outputs are observed and
// inputs driven at the falling edge of that cycle.
module tb_lane_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  lane_y;
  logic        cap;
  logic        cap_ready;
  logic        ser_data;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_sof;
  logic        ser_eof;
  logic        ovf;
  logic        clr_ovf;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  lane_serializer #(.NUM_LANES(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lane_y    (lane_y),
    .cap       (cap),
    .cap_ready (cap_ready),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_sof   (ser_sof),
    .ser_eof   (ser_eof),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    cap       = 1'b0;
    clr_ovf   = 1'b0;
    ser_ready = 1'b0;
    lane_y    = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (cap_ready !== 1'b1) begin n_err++; $display("FAIL reset_cap_ready got %b want 1", cap_ready); end
    n_cmp++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid got %b want 0", ser_valid); end
    n_cmp++; if (ser_data !== 1'b0) begin n_err++; $display("FAIL reset_ser_data got %b want 0", ser_data); end
    n_cmp++; if (ser_sof !== 1'b0) begin n_err++; $display("FAIL reset_ser_sof got %b want 0", ser_sof); end
    n_cmp++; if (ser_eof !== 1'b0) begin n_err++; $display("FAIL reset_ser_eof got %b want 0", ser_eof); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
  endtask

  task automatic test_single_frame();
    logic [7:0]  ev, ed, es, ee;
    logic [3:0]  got, exp;
    logic [15:0] efc;
    ev = 8'b0011_1100; ed = 8'b0010_1000; es = 8'b0000_0100; ee = 8'b0010_0000;
    do_reset();
    ser_ready = 1'b1;
    lane_y    = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      got = {ser_valid, ser_data, ser_sof, ser_eof};
      exp = {ev[k], ed[k], es[k], ee[k]};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL single_beat cyc %0d v/d/sof/eof got %b want %b", k, got, exp); end
      efc = (k >= 6) ? 16'd1 : 16'd0;
      n_cmp++; if (frame_cnt !== efc) begin n_err++; $display("FAIL single_frame_cnt cyc %0d got %0d want %0d", k, frame_cnt, efc); end
      cap = (k == 0);
      @(negedge clk);
    end
    cap = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [11:0] ev, ed, es, ee;
    logic [3:0]  got, exp;
    logic [15:0] efc;
    ev = 12'b0011_1111_1100; ed = 12'b0010_1111_1000;
    es = 12'b0000_0000_0100; ee = 12'b0010_0000_0000;
    do_reset();
    lane_y = 4'b1010;
    for (int k = 0; k < 12; k++) begin
      got = {ser_valid, ser_data, ser_sof, ser_eof};
      exp = {ev[k], ed[k], es[k], ee[k]};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL backpressure_beat cyc %0d v/d/sof/eof got %b want %b", k, got, exp); end
      efc = (k >= 10) ? 16'd1 : 16'd0;
      n_cmp++; if (frame_cnt !== efc) begin n_err++; $display("FAIL backpressure_frame_cnt cyc %0d got %0d want %0d", k, frame_cnt, efc); end
      cap       = (k == 0);
      ser_ready = !(k >= 3 && k <= 6);
      @(negedge clk);
    end
    cap = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] ev, ed, es, ee;
    logic [3:0]  got, exp;
    logic [15:0] efc;
    ev = 12'b0011_1111_1100; ed = 12'b0011_1100_0100;
    es = 12'b0000_0100_0100; ee = 12'b0010_0010_0000;
    do_reset();
    ser_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      got = {ser_valid, ser_data, ser_sof, ser_eof};
      exp = {ev[k], ed[k], es[k], ee[k]};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_beat cyc %0d v/d/sof/eof got %b want %b", k, got, exp); end
      efc = (k >= 10) ? 16'd2 : (k >= 6) ? 16'd1 : 16'd0;
      n_cmp++; if (frame_cnt !== efc) begin n_err++; $display("FAIL b2b_frame_cnt cyc %0d got %0d want %0d", k, frame_cnt, efc); end
      cap    = (k <= 1);
      lane_y = (k == 0) ? 4'b0001 : 4'b1111;
      @(negedge clk);
    end
    cap = 1'b0;
  endtask

  task automatic test_overflow();
    logic [3:0] got;
    logic       erdy, eovf;
    do_reset();
    lane_y = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      erdy = (k < 3);
      eovf = (k == 4 || k == 5);
      n_cmp++; if (cap_ready !== erdy) begin n_err++; $display("FAIL ovf_cap_ready cyc %0d got %b want %b", k, cap_ready, erdy); end
      n_cmp++; if (ovf !== eovf) begin n_err++; $display("FAIL ovf_flag cyc %0d got %b want %b", k, ovf, eovf); end
      if (k >= 2) begin
        got = {ser_valid, ser_data, ser_sof, ser_eof};
        n_cmp++; if (got !== 4'b1010) begin n_err++; $display("FAIL ovf_held_beat cyc %0d got %b want 1010", k, got); end
      end
      cap     = (k <= 4);
      clr_ovf = (k == 4 || k == 5);
      @(negedge clk);
    end
    cap     = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got, exp, fresh;
    fresh = 4'b0101;
    do_reset();
    ser_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      got = {ser_valid, ser_data, ser_sof, ser_eof};
      if (k == 4) begin
        n_cmp++; if (got !== 4'b1000) begin n_err++; $display("FAIL midrst_beat2 got %b want 1000", got); end
      end
      if (k == 5) begin
        n_cmp++; if (got !== 4'b0000) begin n_err++; $display("FAIL midrst_outputs got %b want 0000", got); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
        n_cmp++; if (cap_ready !== 1'b1) begin n_err++; $display("FAIL midrst_cap_ready got %b want 1", cap_ready); end
      end
      if (k >= 8 && k <= 11) begin
        exp = {1'b1, fresh[k-8], (k == 8), (k == 11)};
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL midrst_fresh_beat cyc %0d got %b want %b", k, got, exp); end
      end
      if (k == 12) begin
        n_cmp++; if (got !== 4'b0000) begin n_err++; $display("FAIL midrst_idle_after got %b want 0000", got); end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_fresh_cnt got %0d want 1", frame_cnt); end
      end
      cap    = (k == 0 || k == 6);
      lane_y = (k < 6) ? 4'b1011 : fresh;
      rst_n  = (k != 4);
      @(negedge clk);
    end
    cap   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.frame_cnt = 16'hFFFE;
    @(negedge clk);
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    n_cmp++; if (frame_cnt !== 16'hFFFE) begin n_err++; $display("FAIL wrap_preload got %h want fffe", frame_cnt); end
    ser_ready = 1'b1;
    lane_y    = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        n_cmp++; if (frame_cnt !== 16'hFFFE) begin n_err++; $display("FAIL wrap_before got %h want fffe", frame_cnt); end
      end
      if (k == 6) begin
        n_cmp++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got %h want ffff", frame_cnt); end
      end
      if (k == 10) begin
        n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", frame_cnt); end
      end
      cap = (k <= 1);
      @(negedge clk);
    end
    cap = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Collects per-lane outputs from a generate-built array of lane cells and returns them to the control side as a serial frame. On each capture strobe it snapshots all `NUM_LANES` lane bits into a small buffer. It then transmits each snapshot lane 0 first, one bit per accepted beat, over a valid/ready stream with start/end-of-frame markers. It is the read-back end of the lane array: the array fans a stimulus out, and this block gathers and drains the results.

## Interface
Parameters:
- `NUM_LANES`, 4: lanes per snapshot (≥2); also the frame length in beats.
- `DEPTH`, 2: snapshot buffer entries (power of 2, ≥2).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `lane_y`  in  NUM_LANES: lane outputs; bit i from lane i.
- `cap`  in  1: capture strobe; one snapshot per high cycle.
- `cap_ready`  out  1: buffer has space (count < DEPTH).
- `ser_data`  out  1: current serial bit.
- `ser_valid`  out  1: beat valid.
- `ser_ready`  in  1: sink accepts beat.
- `ser_sof`  out  1: first beat of frame (lane 0).
- `ser_eof`  out  1: last beat of frame (lane NUM_LANES-1).
- `ovf`  out  1: sticky; a capture was dropped.
- `clr_ovf`  in  1: clears `ovf`.
- `frame_cnt`  out  16: frames fully transmitted, wraps 0xFFFF→0.

## Operation
- Capture: `cap && cap_ready` writes `lane_y` at the write pointer; count+1. `cap && !cap_ready` drops the sample and sets `ovf`.
- `cap_ready` comes from the registered count only. There is no same-cycle pass-through when a pop frees space.
- Buffer: circular, log2(DEPTH)-bit pointers with natural wrap, count 0..DEPTH. Push and pop in the same cycle leave count unchanged.
- FSM states:
  - IDLE:
    - Outputs: `ser_valid`=0.
    - If count>0: pop head into shift register, bit index=0, next state SHIFT.
  - SHIFT:
    - Outputs: `ser_valid`=1, `ser_data`=shreg[0], `ser_sof`=(idx==0), `ser_eof`=(idx==NUM_LANES-1).
    - On `ser_valid && ser_ready`, not last beat: shift right, idx+1.
    - On the accepted last beat: `frame_cnt`+1.
      - Count>0 (buffer not empty): pop and reload with idx=0, stay in SHIFT. Back-to-back frames have no gap.
      - Otherwise: go to IDLE.
- While `ser_valid` is high and `ser_ready` is low, `ser_data`, `ser_sof` and `ser_eof` are held stable.
- `ser_data`, `ser_sof` and `ser_eof` are 0 whenever `ser_valid`=0.
- `clr_ovf` and a drop in the same cycle: set wins and `ovf` stays 1.

## Timing
- Reset values (cycle after `rst_n`=0 sampled):
  - State IDLE, pointers 0, count 0.
  - `cap_ready`=1, `ser_valid`=0, `ser_data`=0, `ser_sof`=0, `ser_eof`=0, `ovf`=0, `frame_cnt`=0.
- Reset mid-frame aborts the frame. Buffered snapshots are discarded and `frame_cnt` is not incremented.
- Latency with the block empty and IDLE:
  - `cap` sampled at cycle t.
  - Entry visible at t+1; IDLE pops at t+1.
  - First beat (`ser_valid`, `ser_sof`) at t+2.
  - With `ser_ready` held high, `ser_eof` at t+1+NUM_LANES.
- Throughput: one beat per cycle with `ser_ready` high. A sustained capture rate up to one per NUM_LANES cycles is lossless.
- `frame_cnt` updates the cycle after the accepted eof beat.

## Test plan
- Single frame: `lane_y`=4'b1010, one `cap` at cycle 0, `ser_ready`=1.
  - Beats at cycles 2..5 with data 0,1,0,1.
  - `ser_sof` at 2, `ser_eof` at 5, `frame_cnt`=1 at 6, `ser_valid`=0 at 6.
- Backpressure: same frame, `ser_ready` low cycles 3–6.
  - Beat 1 (data 1, no sof/eof) held stable through cycle 7.
  - `ser_eof` at cycle 9.
- Back-to-back: `cap` at cycles 0 and 1 with 4'b0001 then 4'b1111, `ser_ready`=1.
  - Eight consecutive beats at cycles 2..9: 1,0,0,0,1,1,1,1.
  - `ser_sof` at 2 and 6, `frame_cnt`=2.
- Overflow: `ser_ready`=0, `cap` at cycles 0,1,2 (DEPTH=2, the first entry is popped into the shift register at cycle 1).
  - No drop.
  - `cap` at cycle 3: `cap_ready`=0, sample dropped, `ovf`=1 from cycle 4.
  - `clr_ovf` together with another drop keeps `ovf`=1; `clr_ovf` alone clears it next cycle.
- Reset mid-frame: `rst_n`=0 during beat 2.
  - Next cycle all outputs are at reset values and `frame_cnt`=0.
  - A fresh `cap` afterwards produces a full frame with `ser_sof` first.
- Counter wrap: preload or run 65536 frames; `frame_cnt` goes 0xFFFF→0x0000.
